// File: rtl/mino_frame_collector.sv
// mino_frame_collector
//
// Serial-to-frame front end for the minority detector. Packs every three
// accepted serial bits into a frame {x,y,z}, registers the frame together
// with its minority result, and presents it on a valid/ready output. Frames
// leaving the block are counted (wrapping) and minority frames are counted
// (saturating).
//
// Index FSM:
//   state | meaning
//   IDX0  | expecting x (first bit of a frame)
//   IDX1  | expecting y (x captured)
//   IDX2  | expecting z (x,y captured); z accept loads the output register
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   flush      in   synchronous; discards the partial frame
//   in_valid   in   in_bit is valid this cycle
//   in_bit     in   serial data bit
//   in_ready   out  bit is accepted this cycle (combinational on out_ready)
//   out_valid  out  held frame is valid
//   out_ready  in   downstream takes the held frame this cycle
//   out_xyz    out  held frame, [2]=x [1]=y [0]=z
//   out_mino   out  minority of the held frame
//   frame_cnt  out  frames transferred out, wraps
//   mino_cnt   out  transferred frames with out_mino=1, saturates

module mino_frame_collector #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   input  logic             in_bit,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2:0]       out_xyz,
   output logic             out_mino,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [CNT_W-1:0] mino_cnt
);

   typedef enum logic [1:0] {
      IDX0 = 2'd0,
      IDX1 = 2'd1,
      IDX2 = 2'd2
   } idx_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   idx_t idx;
   idx_t idx_nxt;

   logic accept;
   logic xfer;
   logic load;
   logic bit_x;
   logic bit_y;
   logic frame_mino;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx <= IDX0;
      end else begin
         idx <= idx_nxt;
      end
   end

   // next-state logic; flush wins over any accept in the same cycle
   always_comb begin
      idx_nxt = idx;
      if (flush) begin
         idx_nxt = IDX0;
      end else if (accept) begin
         case (idx)
            IDX0:    idx_nxt = IDX1;
            IDX1:    idx_nxt = IDX2;
            default: idx_nxt = IDX0;
         endcase
      end
   end

   // output / control logic
   // Only the z bit can stall: it needs the output register to be free or
   // draining on this same edge.
   always_comb begin
      in_ready = !((idx == IDX2) && out_valid && !out_ready);
      accept   = in_valid && in_ready;
      xfer     = out_valid && out_ready;
      load     = accept && (idx == IDX2) && !flush;
   end

   assign frame_mino = ~((bit_x & bit_y) | (bit_y & in_bit) | (bit_x & in_bit));

   // partial frame bits
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_x <= 1'b0;
         bit_y <= 1'b0;
      end else if (flush) begin
         bit_x <= 1'b0;
         bit_y <= 1'b0;
      end else if (accept) begin
         if (idx == IDX0) bit_x <= in_bit;
         if (idx == IDX1) bit_y <= in_bit;
      end
   end

   // output register; a load on a transfer edge keeps out_valid high
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_xyz   <= 3'b000;
         out_mino  <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_xyz   <= {bit_x, bit_y, in_bit};
         out_mino  <= frame_mino;
      end else if (xfer) begin
         out_valid <= 1'b0;
      end
   end

   // transfer counters; mino_cnt uses the minority of the frame leaving
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt <= '0;
         mino_cnt  <= '0;
      end else if (xfer) begin
         frame_cnt <= frame_cnt + CNT_ONE;
         if (out_mino && (mino_cnt != CNT_MAX)) begin
            mino_cnt <= mino_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_mino_frame_collector.sv
module tb_mino_frame_collector;

   localparam int W  = 8;
   localparam int W2 = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         flush, in_valid, in_bit, out_ready;
   logic         in_ready, out_valid, out_mino;
   logic [2:0]   out_xyz;
   logic [W-1:0] frame_cnt, mino_cnt;

   logic          flush2, in_valid2, in_bit2, out_ready2;
   logic          in_ready2, out_valid2, out_mino2;
   logic [2:0]    out_xyz2;
   logic [W2-1:0] frame_cnt2, mino_cnt2;

   mino_frame_collector #(.CNT_W(W)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_bit(in_bit),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_xyz(out_xyz), .out_mino(out_mino), .frame_cnt(frame_cnt), .mino_cnt(mino_cnt)
   );

   mino_frame_collector #(.CNT_W(W2)) dut2 (
      .clk(clk), .rst(rst), .flush(flush2), .in_valid(in_valid2), .in_bit(in_bit2),
      .in_ready(in_ready2), .out_valid(out_valid2), .out_ready(out_ready2),
      .out_xyz(out_xyz2), .out_mino(out_mino2), .frame_cnt(frame_cnt2), .mino_cnt(mino_cnt2)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the frame under collection is a queue of accepted bits;
   // a frame completes when the queue reaches three bits.
   bit       q[$];
   bit       m_valid;
   bit [2:0] m_xyz;
   bit       m_mino;
   int       m_fc, m_mc;

   task automatic model_reset();
      q.delete();
      m_valid = 0; m_xyz = 3'b000; m_mino = 0; m_fc = 0; m_mc = 0;
   endtask

   function automatic bit m_in_ready(input bit ordy);
      return !(q.size() == 2 && m_valid && !ordy);
   endfunction

   // one clock cycle: drive, check in_ready, advance model at the edge,
   // compare registered outputs on the following falling edge
   task automatic cyc(input bit v, input bit b, input bit ordy, input bit fl);
      bit acc, xfer, load;
      int ones;
      in_valid = v; in_bit = b; out_ready = ordy; flush = fl;
      #1;
      chk("in_ready", in_ready, m_in_ready(ordy));
      acc  = v && m_in_ready(ordy);
      xfer = m_valid && ordy;
      @(posedge clk);
      load = 0;
      if (xfer) begin
         m_fc = (m_fc + 1) % (1 << W);
         if (m_mino && m_mc < (1 << W) - 1) m_mc++;
      end
      if (fl) begin
         q.delete();
      end else if (acc) begin
         q.push_back(b);
         if (q.size() == 3) begin
            load  = 1;
            m_xyz = {q[0], q[1], q[2]};
            ones  = int'(q[0]) + int'(q[1]) + int'(q[2]);
            m_mino = (ones < 2);
            q.delete();
         end
      end
      if (load) m_valid = 1;
      else if (xfer) m_valid = 0;
      @(negedge clk);
      chk("out_valid", out_valid, m_valid);
      chk("out_xyz", out_xyz, m_xyz);
      chk("out_mino", out_mino, m_mino);
      chk("frame_cnt", frame_cnt, m_fc);
      chk("mino_cnt", mino_cnt, m_mc);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic cyc2(input bit v, input bit b);
      in_valid2 = v; in_bit2 = b;
      @(posedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      bit [2:0] xyz;
      bit       mino;
   } vec_t;

   vec_t vecs[8];

   initial begin
      vecs[0] = '{3'b000, 1'b1};
      vecs[1] = '{3'b001, 1'b1};
      vecs[2] = '{3'b010, 1'b1};
      vecs[3] = '{3'b011, 1'b0};
      vecs[4] = '{3'b100, 1'b1};
      vecs[5] = '{3'b101, 1'b0};
      vecs[6] = '{3'b110, 1'b0};
      vecs[7] = '{3'b111, 1'b0};

      rst = 1'b1; flush = 0; in_valid = 0; in_bit = 0; out_ready = 0;
      flush2 = 0; in_valid2 = 0; in_bit2 = 0; out_ready2 = 1;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // reset mid-frame with a held frame
      cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 1, 0, 0);
      cyc(1, 1, 0, 0);
      chk("pre_rst_valid", out_valid, 1);
      rst = 1'b1;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_xyz", out_xyz, 0);
      chk("rst_out_mino", out_mino, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_mino_cnt", mino_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 0, 0, 0);
      chk("post_rst_xyz", out_xyz, 3'b110);
      chk("post_rst_mino", out_mino, 0);
      pulse_reset();

      // exhaustive frames, output always draining
      for (int i = 0; i < 8; i++) begin
         cyc(1, vecs[i].xyz[2], 1, 0);
         cyc(1, vecs[i].xyz[1], 1, 0);
         cyc(1, vecs[i].xyz[0], 1, 0);
         chk("vec_xyz", out_xyz, vecs[i].xyz);
         chk("vec_mino", out_mino, vecs[i].mino);
      end
      cyc(0, 0, 1, 0);
      chk("exh_frame_cnt", frame_cnt, 8);
      chk("exh_mino_cnt", mino_cnt, 4);

      // backpressure: 001 held, 0,1 accepted, z stalls, then drain + load
      cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 1, 0, 0);
      cyc(1, 0, 0, 0); cyc(1, 1, 0, 0);
      in_valid = 1; in_bit = 0; out_ready = 0; flush = 0;
      #1;
      chk("bp_in_ready", in_ready, 0);
      cyc(1, 0, 0, 0);
      chk("bp_hold_xyz", out_xyz, 3'b001);
      chk("bp_hold_valid", out_valid, 1);
      in_valid = 1; in_bit = 0; out_ready = 1;
      #1;
      chk("bp_release_ready", in_ready, 1);
      cyc(1, 0, 1, 0);
      chk("bp_swap_valid", out_valid, 1);
      chk("bp_swap_xyz", out_xyz, 3'b010);
      chk("bp_swap_cnt", frame_cnt, 9);

      // flush discards partial bits; flush with in_valid drops the bit
      cyc(1, 1, 1, 0); cyc(1, 1, 1, 0); cyc(0, 0, 1, 1);
      cyc(1, 0, 1, 0); cyc(1, 0, 1, 0); cyc(1, 1, 1, 0);
      chk("flush_xyz", out_xyz, 3'b001);
      chk("flush_mino", out_mino, 1);
      cyc(1, 1, 1, 0); cyc(1, 1, 1, 1);
      cyc(1, 0, 1, 0); cyc(1, 1, 1, 0); cyc(1, 1, 1, 0);
      chk("flush_bit_xyz", out_xyz, 3'b011);
      chk("flush_bit_mino", out_mino, 0);
      // flush on the z accept drops the frame
      cyc(1, 0, 1, 0); cyc(1, 0, 1, 0); cyc(1, 0, 1, 1);
      chk("flush_z_valid", out_valid, 0);
      chk("flush_z_xyz", out_xyz, 3'b011);

      // saturation and wrap with a 2-bit counter instance
      for (int i = 0; i < 15; i++) cyc2(1, 0);
      cyc2(0, 0);
      cyc2(0, 0);
      chk("sat_mino_cnt", mino_cnt2, 3);
      chk("wrap_frame_cnt", frame_cnt2, 1);
      chk("sat_out_valid", out_valid2, 0);

      // gapped random traffic against the model
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom % 3) != 0, $urandom % 2, ($urandom % 4) != 0, ($urandom % 25) == 0);
      end
      cyc(0, 0, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mino_frame_collector.md
# mino_frame_collector

Serial-to-frame front end for the minority detector. Accepts a valid-qualified serial bit stream, packs each group of three accepted bits into a frame {x,y,z}, and registers the frame with its minority result (1 when fewer than two of x,y,z are 1). Frames are presented on a valid/ready output and counted. It sits directly upstream of the combinational minority detector and feeds its x, y and z inputs.

## Interface
- `CNT_W`, default 8: width of the frame and minority counters.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous; discards the partial frame under collection.
- `in_valid`  in  1  `in_bit` is valid this cycle.
- `in_bit`  in  1  serial data bit.
- `in_ready`  out  1  collector accepts `in_bit` this cycle (combinational).
- `out_valid`  out  1  the held frame is valid.
- `out_ready`  in  1  the downstream stage takes the frame this cycle.
- `out_xyz`  out  3  held frame; [2]=x, [1]=y, [0]=z.
- `out_mino`  out  1  minority of the held frame.
- `frame_cnt`  out  CNT_W  frames transferred out; wraps.
- `mino_cnt`  out  CNT_W  transferred frames with `out_mino`=1; saturates.

## Operation
- **Input accept:** a bit is accepted when `in_valid` and `in_ready` are both high at the rising edge of `clk`.
- **Bit order:** the first accepted bit of a frame is x, the second is y, the third is z.
- **Index states:** a 2-bit index `idx` tracks the frame position.
  - IDX0 (expect x) moves to IDX1 on accept.
  - IDX1 (expect y) moves to IDX2 on accept.
  - IDX2 (expect z) moves to IDX0 on accept.
  - `idx` never takes the value 3.
- **Frame hand-off:** on the IDX2 accept, {x,y,z} loads into `out_xyz` and `out_mino` = ~((x&y)|(y&z)|(x&z)) loads with it. `out_valid` sets on the same edge.
- **Output handshake:** an output transfer happens when `out_valid` and `out_ready` are both high.
  - Transfer with no new frame loading: `out_valid` clears.
  - Transfer and new frame load on the same edge: `out_valid` stays 1 and the new data replaces the old.
- **Hold rule:** while `out_valid`=1 and `out_ready`=0, `out_xyz` and `out_mino` stay stable.
- **in_ready:** `in_ready` = !(idx==IDX2 && out_valid && !out_ready).
  - x and y bits are always accepted.
  - A z bit stalls only while the output register is occupied and not draining.
- **Counters:** on each output transfer, `frame_cnt` increments by 1 and wraps from 2^CNT_W−1 to 0.
  - `mino_cnt` increments by 1 only if `out_mino`=1, and holds at 2^CNT_W−1.
- **flush:** `idx` returns to IDX0 and the partial x/y bits are discarded.
  - The held output and both counters are unaffected.
  - If `in_valid` is high in a flush cycle, that bit is dropped and `idx` ends at IDX0.
  - A flush in the same cycle as an IDX2 accept also drops the frame; no load occurs.
  - An output transfer in a flush cycle still completes.
- **Reset:** `rst` clears the following.
  - `idx` = IDX0 and the partial bits = 0.
  - `out_valid` = 0, `out_xyz` = 3'b000, `out_mino` = 0.
  - `frame_cnt` = 0, `mino_cnt` = 0.
  - Reset mid-frame or with a held frame discards everything; the first accepted bit after reset is x.

## Timing
- **Latency:** `out_valid` goes high the cycle after the edge that accepts z, giving 1 cycle from z to output.
- **Throughput:** one frame per 3 cycles at full rate; the output drains every frame with `out_ready` tied high.
- **Combinational paths:** `in_ready` depends combinationally on `out_ready`. All other outputs are registered.
- **Counter update:** counters update on the transfer edge and show the new value the following cycle.
- **Reset release:** the first accept can occur on the first rising edge after `rst` deasserts.

## Test plan
- **Reset values:** assert `rst` mid-frame with `out_valid`=1 → all outputs read 0 immediately. After release, stream 1,1,0 → `out_xyz`=3'b110, `out_mino`=0.
- **Exhaustive frames:** with `out_ready`=1, stream all 8 frames 000 to 111 → `out_mino` = 1,1,1,0,1,0,0,0. Then `frame_cnt`=8 and `mino_cnt`=4.
- **Backpressure:**
  - Hold `out_ready`=0 after frame 001.
  - Stream 0,1 then offer z → `in_ready`=0 at IDX2 and `out_xyz` stays 001.
  - Raise `out_ready` → 001 transfers and 010 loads on the same edge, with `out_valid` staying 1.
- **Flush:** stream 1,1, flush, then 0,0,1 → frame 001, `out_mino`=1. A flush with `in_valid`=1 drops the bit.
- **Saturation and wrap:** with CNT_W=2, send 5 minority frames → `mino_cnt`=3 (saturated) and `frame_cnt`=1 (wrapped).
- **Gapped input:** drive `in_valid` low for random cycles between bits → frames match the accepted-bit order and the counters match a reference model.
